icache_responder: RTL

Instruction-side cache servicing the fetch stage's read port in the LC-3b pipeline. It accepts a word address from fetch, returns the 16-bit instruction word with a same-cycle response on a hit, and on a miss fills a 128-bit line from physical memory before responding. It is read-only: no write path, no dirty state.

---
 rtl/icache_responder_pkg.sv | 23 ++
 rtl/icache_responder_if.sv | 29 ++
 rtl/icache_responder_control.sv | 56 +++++
 rtl/icache_responder.sv | 124 ++++++++++++
 4 files changed

// File: rtl/icache_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : icache_responder_pkg
// Brief    : LC-3b instruction cache types, geometry constants and word select.
// Revision : 1.0
// ============================================================================
package icache_responder_pkg;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_line;
    typedef logic [8:0]   lc3b_c_tag;
    typedef logic [2:0]   lc3b_c_index;
    typedef logic [2:0]   lc3b_c_word_sel;

    localparam int NUM_SETS = 8;
    localparam int NUM_WAYS = 2;

    function automatic lc3b_word select_word(input lc3b_line line, input lc3b_c_word_sel sel);
        return line[{sel, 4'b0000} +: 16];
    endfunction

endpackage
`default_nettype wire

// File: rtl/icache_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : icache_responder_if
// Brief    : Fetch read port and physical-memory fill port of the I-cache.
// Revision : 1.0
// ============================================================================
interface icache_responder_if;
    import icache_responder_pkg::*;

    logic [15:0] inst_address;
    logic        inst_read;
    logic [15:0] icache_rdata;
    logic        icache_resp;
    logic [15:0] pmem_address;
    logic        pmem_read;
    lc3b_line    pmem_rdata;
    logic        pmem_resp;

    modport slave (
        input  inst_address, inst_read, pmem_rdata, pmem_resp,
        output icache_rdata, icache_resp, pmem_address, pmem_read
    );

    modport master (
        output inst_address, inst_read, pmem_rdata, pmem_resp,
        input  icache_rdata, icache_resp, pmem_address, pmem_read
    );
endinterface
`default_nettype wire

// File: rtl/icache_responder_control.sv
`default_nettype none
// ============================================================================
// Module   : icache_control
// Brief    : IDLE/FILL controller for the instruction cache.
// Revision : 1.0
// ============================================================================
module icache_control (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic inst_read_i,
    input  wire logic hit_i,
    input  wire logic pmem_resp_i,
    output logic      icache_resp_o,
    output logic      pmem_read_o,
    output logic      load_line_o,
    output logic      latch_addr_o
);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_FILL = 1'b1;

    logic [0:0] state_q;
    logic [0:0] state_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (inst_read_i && !hit_i) state_d = ST_FILL;
            ST_FILL: if (pmem_resp_i)           state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        icache_resp_o = 1'b0;
        pmem_read_o   = 1'b0;
        load_line_o   = 1'b0;
        latch_addr_o  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                icache_resp_o = inst_read_i && hit_i;
                latch_addr_o  = inst_read_i && !hit_i;
            end
            ST_FILL: begin
                pmem_read_o = 1'b1;
                load_line_o = pmem_resp_i;
            end
            default: ;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/icache_responder.sv
`default_nettype none
// ============================================================================
// Module   : icache_responder
// Brief    : 2-way, 8-set, 16-byte-line read-only instruction cache with LRU.
//            Optional hit/miss counters enabled by ICACHE_STATS_EN.
// Revision : 1.0
// ============================================================================
module icache_responder
    import icache_responder_pkg::*;
(
    input  wire logic          clk,
    input  wire logic          rst,
    icache_responder_if.slave  bus
`ifdef ICACHE_STATS_EN
    ,
    output logic [15:0]        hit_count,
    output logic [15:0]        miss_count
`endif
);
    lc3b_c_tag      req_tag;
    lc3b_c_index    req_index;
    lc3b_c_word_sel req_sel;

    assign req_tag   = bus.inst_address[15:7];
    assign req_index = bus.inst_address[6:4];
    assign req_sel   = bus.inst_address[3:1];

    logic unused_addr_bit;
    assign unused_addr_bit = bus.inst_address[0];

    logic [NUM_WAYS-1:0][NUM_SETS-1:0] valid_q;
    logic [NUM_SETS-1:0]               lru_q;
    lc3b_c_tag                         tag_q  [NUM_WAYS][NUM_SETS];
    lc3b_line                          line_q [NUM_WAYS][NUM_SETS];

    lc3b_c_tag   fill_tag_q;
    lc3b_c_index fill_index_q;

    logic [NUM_WAYS-1:0] way_hit;
    logic                hit;
    logic                hit_way;
    logic                victim;
    logic                icache_resp;
    logic                load_line;
    logic                latch_addr;

    for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way_cmp
        assign way_hit[w] = valid_q[w][req_index] && (tag_q[w][req_index] == req_tag);
    end

    assign hit     = |way_hit;
    assign hit_way = way_hit[1];

    // Invalid ways are filled before any valid line is displaced.
    always_comb begin
        victim = lru_q[fill_index_q];
        if (!valid_q[0][fill_index_q])      victim = 1'b0;
        else if (!valid_q[1][fill_index_q]) victim = 1'b1;
    end

    icache_control u_control (
        .clk           (clk),
        .rst           (rst),
        .inst_read_i   (bus.inst_read),
        .hit_i         (hit),
        .pmem_resp_i   (bus.pmem_resp),
        .icache_resp_o (icache_resp),
        .pmem_read_o   (bus.pmem_read),
        .load_line_o   (load_line),
        .latch_addr_o  (latch_addr)
    );

    assign bus.icache_resp  = icache_resp;
    assign bus.icache_rdata = select_word(line_q[hit_way][req_index], req_sel);
    assign bus.pmem_address = {fill_tag_q, fill_index_q, 4'b0000};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q      <= '0;
            lru_q        <= '0;
            fill_tag_q   <= '0;
            fill_index_q <= '0;
        end else begin
            if (latch_addr) begin
                fill_tag_q   <= req_tag;
                fill_index_q <= req_index;
            end
            if (icache_resp) begin
                lru_q[req_index] <= ~hit_way;
            end
            if (load_line) begin
                valid_q[victim][fill_index_q] <= 1'b1;
                lru_q[fill_index_q]           <= ~victim;
            end
        end
    end

    // Data and tag storage carry no reset; valid bits gate their use.
    always_ff @(posedge clk) begin
        if (load_line) begin
            tag_q[victim][fill_index_q]  <= fill_tag_q;
            line_q[victim][fill_index_q] <= bus.pmem_rdata;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [15:0] hit_count_q;
    logic [15:0] miss_count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            if (icache_resp && (hit_count_q != 16'hFFFF))  hit_count_q  <= hit_count_q + 16'd1;
            if (latch_addr && (miss_count_q != 16'hFFFF))  miss_count_q <= miss_count_q + 16'd1;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif
endmodule
`default_nettype wire
